// File: rtl/io_supply_seq.sv
// Power sequencer for N_DOM switchable IO supply rings: ordered ramp-up with
// debounced power-good, pad isolation control, reverse-order power-down and sticky faults.
module io_supply_seq #(
  parameter int N_DOM   = 4,
  parameter int DEB_CYC = 16,
  parameter int TO_CYC  = 1024,
  localparam int IDX_W  = (N_DOM > 1) ? $clog2(N_DOM) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwr_req_i,
  input  logic             fault_clr_i,
  input  logic [N_DOM-1:0] pg_i,
  output logic [N_DOM-1:0] dom_en_o,
  output logic             iso_o,
  output logic             ready_o,
  output logic             busy_o,
  output logic             fault_o,
  output logic [IDX_W-1:0] fault_dom_o
);

  localparam int DEB_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int TO_W  = $clog2(TO_CYC);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DOM - 1);

  typedef enum logic [2:0] {
    S_OFF, S_RAMP, S_SETTLE, S_ON, S_DOWN, S_FAULT
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [TO_W-1:0]  r_to_cnt;
  logic [DEB_W-1:0] r_deb_cnt;
  logic [N_DOM-1:0] r_pg_m;
  logic [N_DOM-1:0] r_pg_s;
  logic [N_DOM-1:0] r_dom_en;
  logic             r_iso;
  logic             r_ready;
  logic             r_busy;
  logic             r_fault;
  logic [IDX_W-1:0] r_fault_dom;

  logic             w_pg_cur;
  logic             w_done;
  logic             w_timeout;
  logic             w_deb_last;
  logic [IDX_W-1:0] w_idx_nxt;

  function automatic logic [IDX_W-1:0] lowest_zero(input logic [N_DOM-1:0] v);
    lowest_zero = '0;
    for (int i = N_DOM - 1; i >= 0; i--) begin
      if (!v[i]) lowest_zero = IDX_W'(i);
    end
  endfunction

  assign w_pg_cur   = r_pg_s[r_idx];
  assign w_deb_last = (r_deb_cnt == DEB_LAST);
  assign w_done     = (r_state == S_SETTLE) && w_pg_cur && w_deb_last;
  assign w_timeout  = (r_to_cnt == TO_LAST);
  assign w_idx_nxt  = r_idx + 1'b1;

  // r_deb_cnt doubles as the power-down spacing timer while in S_DOWN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_OFF;
      r_idx       <= '0;
      r_to_cnt    <= '0;
      r_deb_cnt   <= '0;
      r_pg_m      <= '0;
      r_pg_s      <= '0;
      r_dom_en    <= '0;
      r_iso       <= 1'b1;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_fault     <= 1'b0;
      r_fault_dom <= '0;
    end else begin
      r_pg_m <= pg_i;
      r_pg_s <= r_pg_m;
      case (r_state)
        S_OFF: begin
          r_idx     <= '0;
          r_to_cnt  <= '0;
          r_deb_cnt <= '0;
          if (pwr_req_i) begin
            r_state  <= S_RAMP;
            r_dom_en <= N_DOM'(1);
            r_busy   <= 1'b1;
          end
        end
        S_RAMP, S_SETTLE: begin
          r_to_cnt <= r_to_cnt + 1'b1;
          if (!pwr_req_i) begin
            r_state   <= S_DOWN;
            r_deb_cnt <= '0;
          end else if (w_done) begin
            if (r_idx == IDX_LAST) begin
              r_state <= S_ON;
              r_iso   <= 1'b0;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state             <= S_RAMP;
              r_idx               <= w_idx_nxt;
              r_dom_en[w_idx_nxt] <= 1'b1;
              r_to_cnt            <= '0;
            end
          end else if (w_timeout) begin
            r_state     <= S_FAULT;
            r_fault_dom <= r_idx;
            r_dom_en    <= '0;
            r_iso       <= 1'b1;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_fault     <= 1'b1;
          end else if (!w_pg_cur) begin
            r_state <= S_RAMP;
          end else if (r_state == S_RAMP) begin
            r_state   <= S_SETTLE;
            r_deb_cnt <= '0;
          end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
          end
        end
        S_ON: begin
          if (r_pg_s != '1) begin
            r_state     <= S_FAULT;
            r_fault_dom <= lowest_zero(r_pg_s);
            r_dom_en    <= '0;
            r_iso       <= 1'b1;
            r_ready     <= 1'b0;
            r_fault     <= 1'b1;
          end else if (!pwr_req_i) begin
            r_state   <= S_DOWN;
            r_idx     <= IDX_LAST;
            r_deb_cnt <= '0;
            r_iso     <= 1'b1;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        S_DOWN: begin
          if (w_deb_last) begin
            r_deb_cnt <= '0;
            if (r_dom_en == '0) begin
              r_state <= S_OFF;
              r_busy  <= 1'b0;
            end else begin
              r_dom_en[r_idx] <= 1'b0;
              if (r_idx != '0) r_idx <= r_idx - 1'b1;
            end
          end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
          end
        end
        S_FAULT: begin
          if (fault_clr_i && !pwr_req_i) begin
            r_state <= S_OFF;
            r_fault <= 1'b0;
          end
        end
        default: r_state <= S_OFF;
      endcase
    end
  end

  assign dom_en_o    = r_dom_en;
  assign iso_o       = r_iso;
  assign ready_o     = r_ready;
  assign busy_o      = r_busy;
  assign fault_o     = r_fault;
  assign fault_dom_o = r_fault_dom;

endmodule

// File: tb/tb_io_supply_seq.sv
// Bench for io_supply_seq: directed timing scenarios with literal expectations,
// then randomized traffic, all cross-checked every cycle against a behavioural model.
module tb_io_supply_seq;

  localparam int N_DOM   = 2;
  localparam int DEB_CYC = 4;
  localparam int TO_CYC  = 32;
  localparam int IDX_W   = 1;

  localparam int S_EN0 = 0, S_EN1 = 1, S_RDY = 2, S_BSY = 3, S_FLT = 4, S_ISO = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             pwr_req;
  logic             fault_clr;
  logic [N_DOM-1:0] pg;
  logic [N_DOM-1:0] dom_en;
  logic             iso, ready, busy, fault;
  logic [IDX_W-1:0] fault_dom;

  int n_chk  = 0;
  int n_fail = 0;

  io_supply_seq #(.N_DOM(N_DOM), .DEB_CYC(DEB_CYC), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .pwr_req_i(pwr_req), .fault_clr_i(fault_clr), .pg_i(pg),
    .dom_en_o(dom_en), .iso_o(iso), .ready_o(ready), .busy_o(busy),
    .fault_o(fault), .fault_dom_o(fault_dom)
  );

  always #5 clk = ~clk;

  // Behavioural model: a domain is "up" once its synchronised power-good has been
  // seen DEB_CYC+1 edges in a row (one to notice it, DEB_CYC to debounce).
  typedef enum int {M_OFF, M_UP, M_ON, M_DN, M_FLT} mode_t;
  mode_t            m_mode;
  int               m_cur, m_t, m_run, m_dt;
  logic [N_DOM-1:0] m_en, m_pm, m_ps;
  logic             m_iso, m_ready, m_busy, m_fault;
  logic [IDX_W-1:0] m_fdom;
  bit               m_valid = 1'b0;

  always @(posedge clk) begin : model
    mode_t            md;
    int               cur, t, run, dt, hi;
    logic [N_DOM-1:0] en;
    logic             iso_n, rdy, bsy, flt;
    logic [IDX_W-1:0] fd;
    md = m_mode; cur = m_cur; t = m_t; run = m_run; dt = m_dt; en = m_en;
    iso_n = m_iso; rdy = m_ready; bsy = m_busy; flt = m_fault; fd = m_fdom;
    if (rst) begin
      md = M_OFF; cur = 0; t = 0; run = 0; dt = 0; en = '0;
      iso_n = 1'b1; rdy = 1'b0; bsy = 1'b0; flt = 1'b0; fd = '0;
    end else begin
      case (md)
        M_OFF: if (pwr_req) begin
          md = M_UP; cur = 0; en = 2'b01; t = 0; run = 0; bsy = 1'b1;
        end
        M_UP: begin
          t   = t + 1;
          run = m_ps[cur] ? run + 1 : 0;
          if (!pwr_req) begin
            md = M_DN; dt = 0;
          end else if (run == DEB_CYC + 1) begin
            if (cur == N_DOM - 1) begin
              md = M_ON; iso_n = 1'b0; rdy = 1'b1; bsy = 1'b0;
            end else begin
              cur = cur + 1; en[cur] = 1'b1; t = 0; run = 0;
            end
          end else if (t == TO_CYC) begin
            md = M_FLT; fd = IDX_W'(cur); en = '0;
            iso_n = 1'b1; rdy = 1'b0; bsy = 1'b0; flt = 1'b1;
          end
        end
        M_ON: begin
          if (m_ps != '1) begin
            md = M_FLT;
            for (int d = N_DOM - 1; d >= 0; d--) if (!m_ps[d]) fd = IDX_W'(d);
            en = '0; iso_n = 1'b1; rdy = 1'b0; flt = 1'b1;
          end else if (!pwr_req) begin
            md = M_DN; dt = 0; iso_n = 1'b1; rdy = 1'b0; bsy = 1'b1;
          end
        end
        M_DN: begin
          dt = dt + 1;
          if (dt % DEB_CYC == 0) begin
            if (en == '0) begin
              md = M_OFF; bsy = 1'b0; cur = 0;
            end else begin
              hi = 0;
              for (int d = 0; d < N_DOM; d++) if (en[d]) hi = d;
              en[hi] = 1'b0;
            end
          end
        end
        M_FLT: if (fault_clr && !pwr_req) begin
          md = M_OFF; flt = 1'b0; cur = 0;
        end
        default: md = M_OFF;
      endcase
    end
    m_mode <= md; m_cur <= cur; m_t <= t; m_run <= run; m_dt <= dt; m_en <= en;
    m_iso <= iso_n; m_ready <= rdy; m_busy <= bsy; m_fault <= flt; m_fdom <= fd;
    m_pm <= rst ? '0 : pg;
    m_ps <= rst ? '0 : m_pm;
    if (rst) m_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      n_chk++;
      if ({dom_en, iso, ready, busy, fault, fault_dom} !==
          {m_en, m_iso, m_ready, m_busy, m_fault, m_fdom}) begin
        n_fail++;
        $display("FAIL model_cmp at %0t: dut=%b model=%b (en,iso,rdy,busy,flt,fdom)",
                 $time, {dom_en, iso, ready, busy, fault, fault_dom},
                 {m_en, m_iso, m_ready, m_busy, m_fault, m_fdom});
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic sig(input int s);
    case (s)
      S_EN0:   return dom_en[0];
      S_EN1:   return dom_en[1];
      S_RDY:   return ready;
      S_BSY:   return busy;
      S_FLT:   return fault;
      S_ISO:   return iso;
      default: return 1'b0;
    endcase
  endfunction

  // Count negedges until the selected output reaches val; -1 if the budget expires.
  task automatic wait_sig(input int s, input logic val, input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (sig(s) == val) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic bring_up();
    int n;
    pwr_req = 1'b1;
    for (int d = 0; d < N_DOM; d++) begin
      wait_sig(d, 1'b1, 20, n);
      repeat (2) @(negedge clk);
      pg[d] = 1'b1;
    end
    wait_sig(S_RDY, 1'b1, 20, n);
    chk("bring_up_ready", int'(n > 0), 1);
  endtask

  initial begin
    int         n;
    bit [1:0]   dead;
    int         dly[N_DOM];
    rst = 1'b1; pwr_req = 1'b0; fault_clr = 1'b0; pg = '0;
    dead = '0;
    for (int d = 0; d < N_DOM; d++) dly[d] = 0;
    repeat (3) @(negedge clk);
    chk("reset_state", int'({dom_en, iso, ready, busy, fault, fault_dom}), 'b0010000);
    rst = 1'b0;

    // Power-up: pg arrives 3 cycles after each enable
    pwr_req = 1'b1;
    wait_sig(S_EN0, 1'b1, 4, n);   chk("en0_rise", n, 1);
    repeat (2) @(negedge clk); pg[0] = 1'b1;
    wait_sig(S_EN1, 1'b1, 20, n);  chk("en1_after_pg0", n, 7);
    repeat (2) @(negedge clk); pg[1] = 1'b1;
    wait_sig(S_RDY, 1'b1, 20, n);  chk("ready_after_pg1", n, 7);
    chk("iso_with_ready", iso, 0);
    chk("busy_when_ready", busy, 0);

    // Brown-out on both domains with the request drop seen on the same edge
    repeat (3) @(negedge clk);
    pg = 2'b00;
    repeat (2) @(negedge clk);
    pwr_req = 1'b0;
    wait_sig(S_FLT, 1'b1, 4, n);   chk("brownout_fault", n, 1);
    chk("brownout_dom", fault_dom, 0);
    chk("brownout_en", dom_en, 0);
    chk("brownout_iso", iso, 1);
    pwr_req = 1'b1; fault_clr = 1'b1;
    @(negedge clk); fault_clr = 1'b0;
    @(negedge clk); chk("fault_held_req_high", fault, 1);
    pwr_req = 1'b0; fault_clr = 1'b1;
    @(negedge clk); fault_clr = 1'b0;
    chk("fault_cleared", fault, 0);

    // Power-down with a request re-assertion that must be ignored
    bring_up();
    pwr_req = 1'b0;
    wait_sig(S_ISO, 1'b1, 4, n);   chk("iso_on_down", n, 1);
    pwr_req = 1'b1;
    wait_sig(S_EN1, 1'b0, 8, n);   chk("down_en1_clear", n, 4);
    pg[1] = 1'b0;
    wait_sig(S_EN0, 1'b0, 8, n);   chk("down_en0_clear", n, 4);
    pg[0] = 1'b0;
    wait_sig(S_BSY, 1'b0, 8, n);   chk("down_off", n, 4);
    pwr_req = 1'b0;

    // Timeout: domain 1 never reports good
    repeat (3) @(negedge clk);
    pwr_req = 1'b1;
    wait_sig(S_EN0, 1'b1, 4, n);
    repeat (2) @(negedge clk); pg[0] = 1'b1;
    wait_sig(S_EN1, 1'b1, 20, n);
    wait_sig(S_FLT, 1'b1, 40, n);  chk("timeout_cycles", n, 32);
    chk("timeout_dom", fault_dom, 1);
    chk("timeout_en", dom_en, 0);
    chk("timeout_iso", iso, 1);
    pg = '0; pwr_req = 1'b0; fault_clr = 1'b1;
    @(negedge clk); fault_clr = 1'b0;
    repeat (3) @(negedge clk);

    // One-cycle glitch during debounce, then abort while ramping domain 1
    pwr_req = 1'b1;
    wait_sig(S_EN0, 1'b1, 4, n);
    repeat (2) @(negedge clk); pg[0] = 1'b1;
    repeat (3) @(negedge clk); pg[0] = 1'b0;
    @(negedge clk); pg[0] = 1'b1;
    wait_sig(S_EN1, 1'b1, 20, n);  chk("en1_after_glitch", n, 7);
    pwr_req = 1'b0; pg = '0;
    wait_sig(S_BSY, 1'b0, 20, n);  chk("abort_dom1_off", n, 13);

    // Abort while ramping domain 0
    repeat (3) @(negedge clk);
    pwr_req = 1'b1;
    wait_sig(S_EN0, 1'b1, 4, n);
    pwr_req = 1'b0;
    wait_sig(S_EN0, 1'b0, 10, n);  chk("abort_dom0_en_clear", n, 5);
    wait_sig(S_BSY, 1'b0, 10, n);  chk("abort_dom0_off", n, 4);

    // Reset while settling domain 0
    repeat (3) @(negedge clk);
    pwr_req = 1'b1;
    wait_sig(S_EN0, 1'b1, 4, n);
    repeat (2) @(negedge clk); pg[0] = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_mid_settle", int'({dom_en, iso, ready, busy, fault, fault_dom}), 'b0010000);
    rst = 1'b0; pwr_req = 1'b0; pg = '0;
    repeat (3) @(negedge clk);

    // Randomized traffic: emulated supplies with random ramp delay, glitches and dead rails
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 799) == 0);
      fault_clr = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 69) == 0) begin
        pwr_req = ~pwr_req;
        if (pwr_req)
          for (int d = 0; d < N_DOM; d++) dead[d] = ($urandom_range(0, 4) == 0);
      end
      for (int d = 0; d < N_DOM; d++) begin
        if (dom_en[d] && !dead[d]) begin
          if (dly[d] > 0) begin
            dly[d]--;
            pg[d] = 1'b0;
          end else begin
            pg[d] = ($urandom_range(0, 49) != 0);
          end
        end else begin
          pg[d]  = 1'b0;
          dly[d] = $urandom_range(0, 6);
        end
      end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
